// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch mode controller and its BCD counters.
// The optional lap-hold feature in stopwatch_ctrl is enabled with STOPWATCH_LAP_HOLD_EN.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    PAUSE  = 2'd0,
    RUN    = 2'd1,
    ADJUST = 2'd2
  } state_e;

  localparam int BCD_W     = 4;
  localparam int BLANK_MIN = 1;
  localparam int BLANK_SEC = 0;

  // Splits a 0..99 binary value into {tens, ones} BCD digits.
  function automatic logic [2*BCD_W-1:0] to_bcd2(input int value);
    return {BCD_W'(value / 10), BCD_W'(value % 10)};
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that wraps to 00 after MAX.
// The wrap flag is high while the count sits at MAX, so the next inc wraps it.
module bcd_mod_counter
  import stopwatch_pkg::*;
#(
  parameter int MAX = 59
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [BCD_W-1:0] tens,
  output logic [BCD_W-1:0] ones,
  output logic             wrap
);

  localparam logic [2*BCD_W-1:0] MAX_BCD = to_bcd2(MAX);

  assign wrap = ({tens, ones} == MAX_BCD);

  // clr has priority over inc; a ones digit of 9 carries into the tens digit.
  always_ff @(posedge clk_in) begin
    if (rst || clr) begin
      tens <= '0;
      ones <= '0;
    end else if (inc) begin
      if (wrap) begin
        tens <= '0;
        ones <= '0;
      end else if (ones == BCD_W'(9)) begin
        ones <= '0;
        tens <= tens + 1'b1;
      end else begin
        ones <= ones + 1'b1;
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode controller: RUN/PAUSE/ADJUST sequencing, MM:SS BCD time keeping and blink mask.
// Define STOPWATCH_LAP_HOLD_EN to freeze the displayed digits on a lap pulse while counting continues.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int MAX_MIN = 99,
  parameter int MAX_SEC = 59
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             tick_1hz,
  input  logic             tick_flash,
  input  logic             pause_p,
  input  logic             clear_p,
  input  logic             adj,
  input  logic             sel,
  input  logic             lap_p,
  output logic             div_1hz_en,
  output logic             div_1hz_rst,
  output logic [BCD_W-1:0] min_tens,
  output logic [BCD_W-1:0] min_ones,
  output logic [BCD_W-1:0] sec_tens,
  output logic [BCD_W-1:0] sec_ones,
  output logic [1:0]       blank
);

  localparam logic [1:0] ST_PAUSE  = PAUSE;
  localparam logic [1:0] ST_RUN    = RUN;
  localparam logic [1:0] ST_ADJUST = ADJUST;

  logic [1:0]       state, state_next;
  logic             flash_phase, flash_next;
  logic [1:0]       blank_next;
  logic             adjusting, running, clr_time, count_tick, adj_step;
  logic             sec_inc, min_inc, sec_wrap, unused_min_wrap;
  logic [BCD_W-1:0] live_mt, live_mo, live_st, live_so;

  // Priority is adj > clear_p > pause_p; a tick arriving with pause_p is still counted.
  always_comb begin
    adjusting  = (state == ST_ADJUST) && adj;
    running    = (state == ST_RUN) && !adj;
    clr_time   = clear_p && !adj && (state != ST_ADJUST);
    count_tick = running && tick_1hz && !clear_p;
    adj_step   = adjusting && tick_flash && flash_phase;
    sec_inc    = count_tick || (adj_step && sel);
    min_inc    = (count_tick && sec_wrap) || (adj_step && !sel);

    state_next = state;
    if (adj)
      state_next = ST_ADJUST;
    else if (state != ST_RUN && state != ST_PAUSE)
      state_next = ST_PAUSE;
    else if (clear_p)
      state_next = state;
    else if (pause_p)
      state_next = (state == ST_RUN) ? ST_PAUSE : ST_RUN;

    flash_next = 1'b0;
    if (adjusting)
      flash_next = flash_phase ^ tick_flash;

    // The field being adjusted blinks; the other field stays lit.
    blank_next = 2'b00;
    if (state_next == ST_ADJUST) begin
      if (sel)
        blank_next[BLANK_SEC] = flash_next;
      else
        blank_next[BLANK_MIN] = flash_next;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state       <= ST_PAUSE;
      flash_phase <= 1'b0;
      div_1hz_en  <= 1'b0;
      div_1hz_rst <= 1'b1;
      blank       <= 2'b00;
    end else begin
      state       <= state_next;
      flash_phase <= flash_next;
      div_1hz_en  <= (state_next == ST_RUN);
      div_1hz_rst <= clr_time;
      blank       <= blank_next;
    end
  end

  bcd_mod_counter #(.MAX(MAX_SEC)) u_sec (
    .clk_in (clk_in),
    .rst    (rst),
    .inc    (sec_inc),
    .clr    (clr_time),
    .tens   (live_st),
    .ones   (live_so),
    .wrap   (sec_wrap)
  );

  bcd_mod_counter #(.MAX(MAX_MIN)) u_min (
    .clk_in (clk_in),
    .rst    (rst),
    .inc    (min_inc),
    .clr    (clr_time),
    .tens   (live_mt),
    .ones   (live_mo),
    .wrap   (unused_min_wrap)
  );

`ifdef STOPWATCH_LAP_HOLD_EN
  logic                 hold;
  logic [4*BCD_W-1:0]   held;

  // Hold only survives while staying in RUN; the snapshot is the time shown on the lap cycle.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      hold <= 1'b0;
      held <= '0;
    end else if (clr_time || state_next != ST_RUN) begin
      hold <= 1'b0;
    end else if (state == ST_RUN && lap_p) begin
      hold <= !hold;
      if (!hold)
        held <= {live_mt, live_mo, live_st, live_so};
    end
  end

  assign {min_tens, min_ones, sec_tens, sec_ones} =
    hold ? held : {live_mt, live_mo, live_st, live_so};
`else
  logic unused_lap;
  assign unused_lap = lap_p;
  assign {min_tens, min_ones, sec_tens, sec_ones} = {live_mt, live_mo, live_st, live_so};
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: a vector table, directed corner sequences and random
// stimulus, all compared against a behavioural model of two instances (MAX_MIN 99 and 5).
module tb_stopwatch_ctrl;

  localparam logic [7:0] B_RST = 8'h80;
  localparam logic [7:0] B_T1  = 8'h40;
  localparam logic [7:0] B_TF  = 8'h20;
  localparam logic [7:0] B_PP  = 8'h10;
  localparam logic [7:0] B_CP  = 8'h08;
  localparam logic [7:0] B_ADJ = 8'h04;
  localparam logic [7:0] B_SEL = 8'h02;
  localparam logic [7:0] B_LAP = 8'h01;

  localparam int M_PAUSE = 0;
  localparam int M_RUN   = 1;
  localparam int M_ADJ   = 2;

  typedef struct {
    logic rst, t1, tf, pp, cp, adj, sel, lap;
  } stim_t;

  typedef struct {
    stim_t      in;
    int         mm;
    int         ss;
    logic       en;
    logic [1:0] blank;
    logic       drst;
  } vec_t;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic rst = 1'b1, tick_1hz = 1'b0, tick_flash = 1'b0, pause_p = 1'b0;
  logic clear_p = 1'b0, adj = 1'b0, sel = 1'b0, lap_p = 1'b0;

  logic       en0, drst0, en1, drst1;
  logic [3:0] mt0, mo0, st0, so0, mt1, mo1, st1, so1;
  logic [1:0] bl0, bl1;

  stopwatch_ctrl #(.MAX_MIN(99), .MAX_SEC(59)) dut0 (
    .clk_in(clk_in), .rst(rst), .tick_1hz(tick_1hz), .tick_flash(tick_flash),
    .pause_p(pause_p), .clear_p(clear_p), .adj(adj), .sel(sel), .lap_p(lap_p),
    .div_1hz_en(en0), .div_1hz_rst(drst0),
    .min_tens(mt0), .min_ones(mo0), .sec_tens(st0), .sec_ones(so0), .blank(bl0)
  );

  stopwatch_ctrl #(.MAX_MIN(5), .MAX_SEC(59)) dut1 (
    .clk_in(clk_in), .rst(rst), .tick_1hz(tick_1hz), .tick_flash(tick_flash),
    .pause_p(pause_p), .clear_p(clear_p), .adj(adj), .sel(sel), .lap_p(lap_p),
    .div_1hz_en(en1), .div_1hz_rst(drst1),
    .min_tens(mt1), .min_ones(mo1), .sec_tens(st1), .sec_ones(so1), .blank(bl1)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  // Behavioural model: minutes/seconds as plain integers, one copy per instance.
  int         max_min[2] = '{99, 5};
  int         m_min[2], m_sec[2], m_mode[2], h_min[2], h_sec[2];
  logic       m_flash[2], m_hold[2], m_en[2], m_drst[2];
  logic [1:0] m_blank[2];

  vec_t tbl[$];

  function automatic stim_t mk(input logic [7:0] b);
    stim_t s;
    {s.rst, s.t1, s.tf, s.pp, s.cp, s.adj, s.sel, s.lap} = b;
    return s;
  endfunction

  function automatic logic [15:0] bcd_time(input int m, input int s);
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic void add(input logic [7:0] b, input int mm, input int ss,
                              input logic en, input logic [1:0] bl, input logic drst);
    vec_t v;
    v.in = mk(b); v.mm = mm; v.ss = ss; v.en = en; v.blank = bl; v.drst = drst;
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    else
      pass_cnt++;
  endtask

  task automatic model_step(input int k, input stim_t s);
    if (s.rst) begin
      m_mode[k] = M_PAUSE; m_min[k] = 0; m_sec[k] = 0;
      m_flash[k] = 1'b0; m_hold[k] = 1'b0; m_drst[k] = 1'b1;
    end else begin
      m_drst[k] = 1'b0;
      if (s.adj) begin
        if (m_mode[k] != M_ADJ) begin
          m_mode[k] = M_ADJ;
          m_flash[k] = 1'b0;
        end else if (s.tf) begin
          if (m_flash[k]) begin
            if (s.sel) m_sec[k] = (m_sec[k] == 59) ? 0 : m_sec[k] + 1;
            else       m_min[k] = (m_min[k] == max_min[k]) ? 0 : m_min[k] + 1;
          end
          m_flash[k] = !m_flash[k];
        end
        m_hold[k] = 1'b0;
      end else if (m_mode[k] == M_ADJ) begin
        m_mode[k] = M_PAUSE;
        m_flash[k] = 1'b0;
      end else if (s.cp) begin
        m_min[k] = 0; m_sec[k] = 0; m_drst[k] = 1'b1; m_hold[k] = 1'b0;
      end else if (m_mode[k] == M_RUN) begin
`ifdef STOPWATCH_LAP_HOLD_EN
        if (s.lap) begin
          if (m_hold[k]) m_hold[k] = 1'b0;
          else begin m_hold[k] = 1'b1; h_min[k] = m_min[k]; h_sec[k] = m_sec[k]; end
        end
`endif
        if (s.t1) begin
          m_sec[k]++;
          if (m_sec[k] > 59) begin
            m_sec[k] = 0;
            m_min[k]++;
            if (m_min[k] > max_min[k]) m_min[k] = 0;
          end
        end
        if (s.pp) begin m_mode[k] = M_PAUSE; m_hold[k] = 1'b0; end
      end else if (s.pp) begin
        m_mode[k] = M_RUN;
      end
    end
    m_en[k] = (m_mode[k] == M_RUN);
    m_blank[k] = (m_mode[k] == M_ADJ) ? (s.sel ? {1'b0, m_flash[k]} : {m_flash[k], 1'b0}) : 2'b00;
  endtask

  function automatic logic [19:0] model_out(input int k);
    int dm, ds;
    dm = m_hold[k] ? h_min[k] : m_min[k];
    ds = m_hold[k] ? h_sec[k] : m_sec[k];
    return {bcd_time(dm, ds), m_blank[k], m_en[k], m_drst[k]};
  endfunction

  task automatic checkOutput(input string name);
    check({name, " dut0"}, 32'({mt0, mo0, st0, so0, bl0, en0, drst0}), 32'(model_out(0)));
    check({name, " dut1"}, 32'({mt1, mo1, st1, so1, bl1, en1, drst1}), 32'(model_out(1)));
  endtask

  // Drive one cycle of inputs, advance the model on the edge, then compare just after it.
  task automatic applyStimulus(input stim_t s, input string name);
    {rst, tick_1hz, tick_flash, pause_p, clear_p, adj, sel, lap_p} =
      {s.rst, s.t1, s.tf, s.pp, s.cp, s.adj, s.sel, s.lap};
    @(posedge clk_in);
    for (int k = 0; k < 2; k++) model_step(k, s);
    #1;
    checkOutput(name);
  endtask

  task automatic apply(input logic [7:0] b, input string name);
    applyStimulus(mk(b), name);
  endtask

  task automatic repeat_apply(input logic [7:0] b, input int n, input string name);
    for (int i = 0; i < n; i++) apply(b, name);
  endtask

  function automatic logic [15:0] digits0();
    return {mt0, mo0, st0, so0};
  endfunction

  function automatic logic [15:0] digits1();
    return {mt1, mo1, st1, so1};
  endfunction

  initial begin
    logic adj_lvl, sel_lvl;
    logic [7:0] b;

    // Table: {inputs, expected dut0 time/en/blank/div_rst}
    add(B_RST,                0, 0, 1'b0, 2'b00, 1'b1);
    add(8'h00,                0, 0, 1'b0, 2'b00, 1'b0);
    add(B_PP,                 0, 0, 1'b1, 2'b00, 1'b0);
    add(B_T1,                 0, 1, 1'b1, 2'b00, 1'b0);
    add(B_T1,                 0, 2, 1'b1, 2'b00, 1'b0);
    add(B_T1 | B_PP,          0, 3, 1'b0, 2'b00, 1'b0);
    add(B_T1,                 0, 3, 1'b0, 2'b00, 1'b0);
    add(B_PP,                 0, 3, 1'b1, 2'b00, 1'b0);
    add(B_T1 | B_CP,          0, 0, 1'b1, 2'b00, 1'b1);
    add(B_T1,                 0, 1, 1'b1, 2'b00, 1'b0);
    add(B_ADJ | B_SEL,        0, 1, 1'b0, 2'b00, 1'b0);
    add(B_ADJ | B_SEL | B_TF, 0, 1, 1'b0, 2'b01, 1'b0);
    add(B_ADJ | B_SEL | B_TF, 0, 2, 1'b0, 2'b00, 1'b0);
    add(B_ADJ | B_TF,         0, 2, 1'b0, 2'b10, 1'b0);
    add(B_ADJ | B_TF,         1, 2, 1'b0, 2'b00, 1'b0);
    add(8'h00,                1, 2, 1'b0, 2'b00, 1'b0);
    add(B_CP,                 0, 0, 1'b0, 2'b00, 1'b1);
    add(B_PP | B_CP,          0, 0, 1'b0, 2'b00, 1'b1);
    add(B_PP,                 0, 0, 1'b1, 2'b00, 1'b0);
    add(B_ADJ | B_PP,         0, 0, 1'b0, 2'b00, 1'b0);

    foreach (tbl[i]) begin
      applyStimulus(tbl[i].in, "table model");
      check($sformatf("table row %0d", i), 32'({mt0, mo0, st0, so0, bl0, en0, drst0}),
            32'({bcd_time(tbl[i].mm, tbl[i].ss), tbl[i].blank, tbl[i].en, tbl[i].drst}));
    end

    // Run 61 seconds from reset
    apply(B_RST, "A rst");
    apply(B_PP, "A start");
    check("A en after pause_p", 32'(en0), 32'(1));
    repeat_apply(B_T1, 61, "A count");
    check("A 01:01", 32'(digits0()), 32'(bcd_time(1, 1)));

    // Preload 05:59 by adjust, then one tick wraps the MAX_MIN=5 instance
    apply(B_RST, "B rst");
    apply(B_ADJ, "B adj enter");
    repeat_apply(B_ADJ | B_TF, 10, "B adj min");
    repeat_apply(B_ADJ | B_SEL | B_TF, 118, "B adj sec");
    apply(8'h00, "B adj exit");
    check("B 05:59 dut1", 32'(digits1()), 32'(bcd_time(5, 59)));
    apply(B_PP, "B run");
    apply(B_T1, "B tick");
    check("B wrap dut1", 32'(digits1()), 32'(bcd_time(0, 0)));
    check("B carry dut0", 32'(digits0()), 32'(bcd_time(6, 0)));
    // Continue to 99:59 on the default instance
    apply(B_ADJ, "B adj enter2");
    repeat_apply(B_ADJ | B_TF, 186, "B adj min2");
    repeat_apply(B_ADJ | B_SEL | B_TF, 118, "B adj sec2");
    apply(8'h00, "B adj exit2");
    check("B 99:59 dut0", 32'(digits0()), 32'(bcd_time(99, 59)));
    apply(B_PP, "B run2");
    apply(B_T1, "B tick2");
    check("B wrap dut0", 32'(digits0()), 32'(bcd_time(0, 0)));

    // Tick and pause together at 00:10
    apply(B_RST, "C rst");
    apply(B_PP, "C run");
    repeat_apply(B_T1, 10, "C count");
    apply(B_T1 | B_PP, "C tick+pause");
    check("C 00:11", 32'(digits0()), 32'(bcd_time(0, 11)));
    check("C en off", 32'(en0), 32'(0));
    apply(B_T1, "C tick ignored");
    check("C still 00:11", 32'(digits0()), 32'(bcd_time(0, 11)));

    // Adjust seconds from 00:58, seconds wrap without minute carry
    apply(B_RST, "D rst");
    apply(B_PP, "D run");
    repeat_apply(B_T1, 58, "D count");
    apply(B_PP, "D pause");
    apply(B_ADJ | B_SEL, "D adj enter");
    for (int i = 1; i <= 8; i++) begin
      apply(B_ADJ | B_SEL | B_TF, "D flash");
      check($sformatf("D blank tick %0d", i), 32'(bl0), 32'((i % 2 == 1) ? 2'b01 : 2'b00));
      check($sformatf("D time tick %0d", i), 32'(digits0()), 32'(bcd_time(0, (58 + i / 2) % 60)));
    end
    apply(8'h00, "D adj exit");
    check("D exit blank/en", 32'({bl0, en0}), 32'(0));

    // Clear with tick at 03:27, then reset in the middle of adjust
    apply(B_RST, "E rst");
    apply(B_PP, "E run");
    repeat_apply(B_T1, 207, "E count");
    check("E 03:27", 32'(digits0()), 32'(bcd_time(3, 27)));
    apply(B_T1 | B_CP, "E clear+tick");
    check("E cleared", 32'({digits0(), drst0, en0}), 32'({bcd_time(0, 0), 2'b11}));
    apply(8'h00, "E after clear");
    check("E drst one cycle, still run", 32'({drst0, en0}), 32'(2'b01));
    apply(B_ADJ | B_SEL, "E adj");
    repeat_apply(B_ADJ | B_SEL | B_TF, 3, "E adj flash");
    apply(B_RST | B_ADJ, "E rst in adjust");
    check("E rst state", 32'({digits0(), bl0, en0}), 32'(0));
    apply(8'h00, "E idle");

    // Lap hold at 00:05
    apply(B_RST, "F rst");
    apply(B_PP, "F run");
    repeat_apply(B_T1, 5, "F count");
    apply(B_LAP, "F lap");
    check("F lap 00:05", 32'(digits0()), 32'(bcd_time(0, 5)));
    for (int i = 1; i <= 3; i++) begin
      apply(B_T1, "F tick");
`ifdef STOPWATCH_LAP_HOLD_EN
      check($sformatf("F held %0d", i), 32'(digits0()), 32'(bcd_time(0, 5)));
`else
      check($sformatf("F live %0d", i), 32'(digits0()), 32'(bcd_time(0, 5 + i)));
`endif
    end
    apply(B_LAP, "F lap release");
    check("F 00:08", 32'(digits0()), 32'(bcd_time(0, 8)));

    // Random stimulus against the model
    adj_lvl = 1'b0;
    sel_lvl = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(39) == 0) adj_lvl = ~adj_lvl;
      if ($urandom_range(19) == 0) sel_lvl = ~sel_lvl;
      b = {($urandom_range(299) == 0), ($urandom_range(2) == 0), ($urandom_range(2) == 0),
           ($urandom_range(9) == 0), ($urandom_range(29) == 0), adj_lvl, sel_lvl,
           ($urandom_range(7) == 0)};
      apply(b, "random");
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
